// File: rtl/beeb_mailbox_pkg.sv
// Shared constants and types for the BBC Micro bus mailbox.
package beeb_mailbox_pkg;

    // Register offsets within the 4-byte host window
    localparam logic [1:0] OFF_STATUS  = 2'd0;
    localparam logic [1:0] OFF_DATA    = 2'd1;
    localparam logic [1:0] OFF_CONTROL = 2'd2;
    localparam logic [1:0] OFF_COUNT   = 2'd3;

    // STATUS bit positions
    localparam int unsigned STAT_H2I_FULL   = 7;
    localparam int unsigned STAT_I2H_NE     = 6;
    localparam int unsigned STAT_OVERFLOW   = 5;
    localparam int unsigned STAT_IRQ_PEND   = 0;

    // CONTROL bit positions
    localparam int unsigned CTRL_IRQ_EN = 0;
    localparam int unsigned CTRL_FLUSH  = 7;

    // Host bus cycle tracker
    typedef enum logic [1:0] {
        IDLE,
        RD_SEL,
        WR_SEL,
        UNSEL
    } state_t;

    // Occupancy as an 8-bit register value, clamped at 255
    function automatic logic [7:0] sat_count(input logic [8:0] cnt);
        return cnt[8] ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// 8-bit first-word-fall-through FIFO with synchronous flush and occupancy output.
module mailbox_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic [CW-1:0] o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Acceptance is judged on the occupancy at the start of the clock
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_empty   = (r_count == '0);
        w_push_ok = i_push && !w_full;
        w_pop_ok  = i_pop && !w_empty;
    end

    // Storage array; contents need no reset since occupancy gates visibility
    always_ff @(posedge i_clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; flush overrides any coincident push or pop
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/beeb_bus_mailbox.sv
// BBC Micro 1 MHz bus mailbox: 4-byte register window with a FIFO in each direction.
// Optional feature macro: BEEB_MAILBOX_IRQ_EN (host interrupt and CONTROL irq_enable).
module beeb_bus_mailbox
    import beeb_mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFCA0,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NSYNC      = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_phi2,
    input  logic [15:0] i_addr,
    input  logic        i_rnw,
    input  logic [7:0]  i_data_in,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    output logic        o_irq_n,
    input  logic [7:0]  i_i2h_data,
    input  logic        i_i2h_valid,
    output logic        o_i2h_ready,
    output logic [7:0]  o_h2i_data,
    output logic        o_h2i_valid,
    input  logic        i_h2i_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = 27;

    // Synchroniser: a constant 1 rides along so decode waits until the chain holds real samples
    logic [SW-1:0] r_sync [NSYNC];
    logic [SW-1:0] w_sync_in;
    logic          w_vld;
    logic          w_phi2_s;
    logic          w_rnw_s;
    logic [15:0]   w_addr_s;
    logic [7:0]    w_din_s;

    state_t        r_state;
    state_t        w_state_d;
    logic          r_phi2_prev;
    logic [1:0]    r_off;
    logic          r_pop_pend;
    logic [7:0]    r_wdata;
    logic [7:0]    r_data_out;
    logic          r_data_oe;
    logic          r_ovf;

    logic          w_rise;
    logic          w_fall;
    logic          w_hit;
    logic          w_start_hit;
    logic          w_start_rd;
    logic          w_end_rd;
    logic          w_end_wr;
    logic          w_i2h_pop;
    logic          w_h2i_push;
    logic          w_wr_ctrl;
    logic          w_flush;
    logic          w_clr_ovf;
    logic [7:0]    w_status;
    logic [7:0]    w_control;
    logic [7:0]    w_rd_data;

    logic [7:0]    w_i2h_head;
    logic [CW-1:0] w_i2h_count;
    logic [CW-1:0] w_h2i_count;
    logic          w_i2h_full;
    logic          w_i2h_nonempty;
    logic          w_h2i_full;
    logic          w_h2i_empty;
    logic          w_irq_enable;
    logic          w_irq_pending;

    assign w_sync_in = {1'b1, i_phi2, i_rnw, i_addr, i_data_in};

    // Identical register chains keep phi2, rnw, addr and data cycle-aligned
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NSYNC; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_sync_in;
            for (int i = 1; i < NSYNC; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign {w_vld, w_phi2_s, w_rnw_s, w_addr_s, w_din_s} = r_sync[NSYNC-1];

    // FIFO status derived from occupancy
    always_comb begin
        w_i2h_full     = (w_i2h_count == CW'(FIFO_DEPTH));
        w_i2h_nonempty = (w_i2h_count != '0);
        w_h2i_full     = (w_h2i_count == CW'(FIFO_DEPTH));
        w_h2i_empty    = (w_h2i_count == '0);
    end

    // Edge detect, FSM next state and the strobes fired at the end of a host cycle
    always_comb begin
        w_rise      = w_vld && w_phi2_s && !r_phi2_prev;
        w_fall      = w_vld && !w_phi2_s && r_phi2_prev;
        w_hit       = (w_addr_s[15:2] == BASE_ADDR[15:2]);
        w_start_hit = (r_state == IDLE) && w_rise && w_hit;
        w_start_rd  = w_start_hit && w_rnw_s;
        w_end_rd    = (r_state == RD_SEL) && w_fall;
        w_end_wr    = (r_state == WR_SEL) && w_fall;
        w_i2h_pop   = w_end_rd && (r_off == OFF_DATA) && r_pop_pend;
        w_clr_ovf   = w_end_rd && (r_off == OFF_STATUS);
        w_h2i_push  = w_end_wr && (r_off == OFF_DATA);
        w_wr_ctrl   = w_end_wr && (r_off == OFF_CONTROL);
        w_flush     = w_wr_ctrl && r_wdata[CTRL_FLUSH];

        w_state_d = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    if (!w_hit) begin
                        w_state_d = UNSEL;
                    end else if (w_rnw_s) begin
                        w_state_d = RD_SEL;
                    end else begin
                        w_state_d = WR_SEL;
                    end
                end
            end
            RD_SEL, WR_SEL, UNSEL: begin
                if (w_fall) begin
                    w_state_d = IDLE;
                end
            end
        endcase
    end

    // Read data mux, sampled once as the read cycle is decoded
    always_comb begin
        w_status                = '0;
        w_status[STAT_H2I_FULL] = w_h2i_full;
        w_status[STAT_I2H_NE]   = w_i2h_nonempty;
        w_status[STAT_OVERFLOW] = r_ovf;
        w_status[STAT_IRQ_PEND] = w_irq_pending;

        w_control              = '0;
        w_control[CTRL_IRQ_EN] = w_irq_enable;

        unique case (w_addr_s[1:0])
            OFF_STATUS:  w_rd_data = w_status;
            OFF_DATA:    w_rd_data = w_i2h_nonempty ? w_i2h_head : 8'hFF;
            OFF_CONTROL: w_rd_data = w_control;
            OFF_COUNT:   w_rd_data = sat_count(9'(w_i2h_count));
        endcase
    end

    // Bus-cycle state, captured read/write data and sticky overflow
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_phi2_prev <= 1'b1;    // forces a genuine low sample before the next rise
            r_off       <= OFF_STATUS;
            r_pop_pend  <= 1'b0;
            r_wdata     <= 8'h00;
            r_data_out  <= 8'hFF;
            r_data_oe   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_data_oe <= (w_state_d == RD_SEL);
            if (w_vld) begin
                r_phi2_prev <= w_phi2_s;
            end
            // Last data sample seen while phi2 was still high
            if (w_vld && w_phi2_s) begin
                r_wdata <= w_din_s;
            end
            if (w_start_hit) begin
                r_off <= w_addr_s[1:0];
            end
            if (w_start_rd) begin
                r_data_out <= w_rd_data;
                r_pop_pend <= (w_addr_s[1:0] == OFF_DATA) && w_i2h_nonempty;
            end
            if (w_h2i_push && w_h2i_full) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef BEEB_MAILBOX_IRQ_EN
    logic r_irq_en;
    logic r_irq_n;

    // Interrupt enable and registered active-low interrupt
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_irq_en <= 1'b0;
            r_irq_n  <= 1'b1;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= r_wdata[CTRL_IRQ_EN];
            end
            r_irq_n <= !(r_irq_en && w_i2h_nonempty);
        end
    end

    assign w_irq_enable  = r_irq_en;
    assign w_irq_pending = r_irq_en && w_i2h_nonempty;
    assign o_irq_n       = r_irq_n;
`else
    assign w_irq_enable  = 1'b0;
    assign w_irq_pending = 1'b0;
    assign o_irq_n       = 1'b1;
`endif

    mailbox_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_i2h_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_push  (i_i2h_valid),
        .i_data  (i_i2h_data),
        .i_pop   (w_i2h_pop),
        .o_data  (w_i2h_head),
        .o_count (w_i2h_count)
    );

    mailbox_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_h2i_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_push  (w_h2i_push),
        .i_data  (r_wdata),
        .i_pop   (i_h2i_ready),
        .o_data  (o_h2i_data),
        .o_count (w_h2i_count)
    );

    assign o_data_out  = r_data_out;
    assign o_data_oe   = r_data_oe;
    assign o_i2h_ready = !w_i2h_full;
    assign o_h2i_valid = !w_h2i_empty;

endmodule

// File: tb/tb_beeb_bus_mailbox.sv
// Directed bench for beeb_bus_mailbox: table of host cycles plus multi-cycle sequences.
module tb_beeb_bus_mailbox;

`ifdef BEEB_MAILBOX_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        phi2;
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        irq_n;
    logic [7:0]  i2h_data;
    logic        i2h_valid;
    logic        i2h_ready;
    logic [7:0]  h2i_data;
    logic        h2i_valid;
    logic        h2i_ready;

    int n_checks = 0;
    int n_errors = 0;

    beeb_bus_mailbox dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_phi2      (phi2),
        .i_addr      (addr),
        .i_rnw       (rnw),
        .i_data_in   (data_in),
        .o_data_out  (data_out),
        .o_data_oe   (data_oe),
        .o_irq_n     (irq_n),
        .i_i2h_data  (i2h_data),
        .i_i2h_valid (i2h_valid),
        .o_i2h_ready (i2h_ready),
        .o_h2i_data  (h2i_data),
        .o_h2i_valid (h2i_valid),
        .i_h2i_ready (h2i_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rnw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic        exp_oe;
        logic        exp_hv;
        logic [7:0]  exp_hd;
    } vec_t;

    vec_t vecs[14];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One full host bus cycle: 6 clocks with phi2 high, 6 with phi2 low
    task automatic host_cycle(input logic r, input logic [15:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output logic oe_hi);
        @(negedge clock);
        rnw     = r;
        addr    = a;
        data_in = d;
        phi2    = 1'b1;
        repeat (6) @(negedge clock);
        rd    = data_out;
        oe_hi = data_oe;
        phi2  = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic       oe;
        host_cycle(1'b0, a, d, rd, oe);
        check1("write_oe", oe, 1'b0);
    endtask

    task automatic host_read(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] rd;
        logic       oe;
        host_cycle(1'b1, a, 8'h00, rd, oe);
        check1({name, "_oe"}, oe, 1'b1);
        check8(name, rd, exp);
    endtask

    task automatic push_i2h(input logic [7:0] d);
        @(negedge clock);
        i2h_valid = 1'b1;
        i2h_data  = d;
        @(negedge clock);
        i2h_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       oe;
        int         deliveries;

        vecs[0]  = '{1'b0, 16'hFCA1, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[1]  = '{1'b1, 16'hFCA3, 8'h00, 8'h02, 1'b1, 1'b1, 8'h5A};
        vecs[2]  = '{1'b1, 16'hFCA1, 8'h00, 8'h11, 1'b1, 1'b1, 8'h5A};
        vecs[3]  = '{1'b1, 16'hFCA1, 8'h00, 8'h22, 1'b1, 1'b1, 8'h5A};
        vecs[4]  = '{1'b1, 16'hFCB1, 8'h00, 8'h22, 1'b0, 1'b1, 8'h5A};
        vecs[5]  = '{1'b1, 16'hFCA1, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h5A};
        vecs[6]  = '{1'b1, 16'hFCA3, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A};
        vecs[7]  = '{1'b1, 16'hFCA0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A};
        vecs[8]  = '{1'b1, 16'hFCA2, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A};
        vecs[9]  = '{1'b0, 16'hFCA0, 8'h33, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[10] = '{1'b0, 16'hFCA3, 8'h44, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[11] = '{1'b0, 16'hFCB1, 8'h77, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[12] = '{1'b0, 16'hFCA2, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 16'hFCA0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};

        reset     = 1'b1;
        phi2      = 1'b0;
        addr      = 16'h0000;
        rnw       = 1'b1;
        data_in   = 8'h00;
        i2h_data  = 8'h00;
        i2h_valid = 1'b0;
        h2i_ready = 1'b0;

        repeat (3) @(negedge clock);
        check1("rst_oe", data_oe, 1'b0);
        check8("rst_data_out", data_out, 8'hFF);
        check1("rst_irq_n", irq_n, 1'b1);
        check1("rst_h2i_valid", h2i_valid, 1'b0);
        check1("rst_i2h_ready", i2h_ready, 1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Table-driven register map walk
        push_i2h(8'h11);
        push_i2h(8'h22);
        for (int i = 0; i < 14; i++) begin
            host_cycle(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, rd, oe);
            check1($sformatf("vec%0d_oe_hi", i), oe, vecs[i].exp_oe);
            if (vecs[i].rnw) begin
                check8($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            end
            check1($sformatf("vec%0d_oe_lo", i), data_oe, 1'b0);
            check1($sformatf("vec%0d_h2i_valid", i), h2i_valid, vecs[i].exp_hv);
            if (vecs[i].exp_hv) begin
                check8($sformatf("vec%0d_h2i_data", i), h2i_data, vecs[i].exp_hd);
            end
        end

        // Overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            host_write(16'hFCA1, 8'h30 + 8'(i));
        end
        host_read("status_ovf", 16'hFCA0, 8'hA0);
        host_read("status_ovf_clr", 16'hFCA0, 8'h80);
        for (int i = 0; i < 16; i++) begin
            check8($sformatf("drain%0d", i), {7'b0, h2i_valid} ^ h2i_data, 8'h01 ^ (8'h30 + 8'(i)));
            h2i_ready = 1'b1;
            @(negedge clock);
            h2i_ready = 1'b0;
        end
        check1("drain_empty", h2i_valid, 1'b0);

        // Interrupt enable and clear-by-pop
        host_write(16'hFCA2, 8'h01);
        check1("irq_idle", irq_n, 1'b1);
        push_i2h(8'hAB);
        repeat (3) @(negedge clock);
        check1("irq_asserted", irq_n, !IRQ_BUILD);
        host_read("irq_status", 16'hFCA0, IRQ_BUILD ? 8'h41 : 8'h40);
        host_read("irq_control", 16'hFCA2, IRQ_BUILD ? 8'h01 : 8'h00);
        host_read("irq_data", 16'hFCA1, 8'hAB);
        check1("irq_released", irq_n, 1'b1);
        host_write(16'hFCA2, 8'h00);

        // Flush both FIFOs while holding data
        for (int i = 0; i < 3; i++) begin
            host_write(16'hFCA1, 8'h60 + 8'(i));
        end
        push_i2h(8'h71);
        push_i2h(8'h72);
        host_write(16'hFCA2, 8'h80);
        check1("flush_h2i_valid", h2i_valid, 1'b0);
        check1("flush_i2h_ready", i2h_ready, 1'b1);
        deliveries = 0;
        h2i_ready  = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (h2i_valid) deliveries++;
        end
        h2i_ready = 1'b0;
        check8("flush_deliveries", 8'(deliveries), 8'h00);
        host_read("flush_count", 16'hFCA3, 8'h00);
        host_read("flush_data", 16'hFCA1, 8'hFF);
        host_write(16'hFCA1, 8'h99);
        check1("post_flush_valid", h2i_valid, 1'b1);
        check8("post_flush_data", h2i_data, 8'h99);
        h2i_ready = 1'b1;
        @(negedge clock);
        h2i_ready = 1'b0;

        // i2h full boundary
        for (int i = 0; i < 16; i++) begin
            push_i2h(8'hC0 + 8'(i));
        end
        check1("i2h_full_ready", i2h_ready, 1'b0);
        push_i2h(8'hD0);
        host_read("i2h_full_count", 16'hFCA3, 8'h10);
        host_read("i2h_full_head", 16'hFCA1, 8'hC0);
        host_read("i2h_after_pop", 16'hFCA3, 8'h0F);
        check1("i2h_ready_again", i2h_ready, 1'b1);
        host_write(16'hFCA2, 8'h80);

        // Reset in the middle of a read cycle
        push_i2h(8'h5E);
        @(negedge clock);
        rnw  = 1'b1;
        addr = 16'hFCA1;
        phi2 = 1'b1;
        repeat (5) @(negedge clock);
        check1("midrd_oe", data_oe, 1'b1);
        reset = 1'b1;
        #1;
        check1("midrd_reset_oe", data_oe, 1'b0);
        check8("midrd_reset_dout", data_out, 8'hFF);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        push_i2h(8'h6F);
        repeat (4) @(negedge clock);
        check1("midrd_no_decode", data_oe, 1'b0);
        phi2 = 1'b0;
        repeat (6) @(negedge clock);
        check1("midrd_after_fall_oe", data_oe, 1'b0);
        host_read("midrd_count", 16'hFCA3, 8'h01);
        host_read("midrd_data", 16'hFCA1, 8'h6F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
